// File: rtl/lsu_axi_master.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_axi_master
//  Description : AXI4-Lite initiator for the load/store unit. Accepts one
//                byte/half/word request at a time, issues a single
//                word-aligned beat on AR/R or AW/W/B, builds write strobes,
//                extracts and extends load data, and returns one response.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_axi_master (
  input  logic        clk,
  input  logic        rst,
  // execute-stage request
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  // execute-stage response
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // AXI4-Lite read address / data
  output logic [31:0] maxi_araddr,
  output logic        maxi_arvalid,
  input  logic        maxi_arready,
  input  logic [31:0] maxi_rdata,
  input  logic [1:0]  maxi_rresp,
  input  logic        maxi_rvalid,
  output logic        maxi_rready,
  // AXI4-Lite write address / data / response
  output logic [31:0] maxi_awaddr,
  output logic        maxi_awvalid,
  input  logic        maxi_awready,
  output logic [31:0] maxi_wdata,
  output logic [3:0]  maxi_wstrb,
  output logic        maxi_wvalid,
  input  logic        maxi_wready,
  input  logic [1:0]  maxi_bresp,
  input  logic        maxi_bvalid,
  output logic        maxi_bready
);

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t      state;
  state_t      state_next;

  // Request attributes held for the whole transaction.
  logic [1:0]  offset;
  logic [1:0]  offset_next;
  logic [1:0]  size;
  logic [1:0]  size_next;
  logic        zext;
  logic        zext_next;

  // Next values of every registered output.
  logic        req_ready_next;
  logic        resp_valid_next;
  logic [31:0] resp_rdata_next;
  logic        resp_err_next;
  logic [31:0] araddr_next;
  logic        arvalid_next;
  logic        rready_next;
  logic [31:0] awaddr_next;
  logic        awvalid_next;
  logic [31:0] wdata_next;
  logic [3:0]  wstrb_next;
  logic        wvalid_next;
  logic        bready_next;

  // Handshake bookkeeping for the write address/data pair.
  logic        aw_done;
  logic        w_done;
  logic        misaligned;

  // Size 3 is never legal; halves need an even address, words a 4-byte one.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic bad;
    case (sz)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = (off != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte lanes touched by an aligned access starting at lane 'off'.
  function automatic logic [3:0] make_strobe(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] strb;
    case (sz)
      SIZE_BYTE: strb = 4'b0001 << off;
      SIZE_HALF: strb = 4'b0011 << off;
      default:   strb = 4'b1111 << off;
    endcase
    return strb;
  endfunction

  // Move the addressed bytes down to bit 0 and sign- or zero-extend them.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [1:0]  sz,
                                              input logic        zero_ext);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = word >> {off, 3'b000};
    case (sz)
      SIZE_BYTE: result = {{24{~zero_ext & shifted[7]}},  shifted[7:0]};
      SIZE_HALF: result = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
      default:   result = shifted;
    endcase
    return result;
  endfunction

  assign misaligned = is_misaligned(req_size, req_addr[1:0]);
  assign aw_done    = ~maxi_awvalid | maxi_awready;
  assign w_done     = ~maxi_wvalid  | maxi_wready;

  // Next-state and next-output decode; every output holds unless changed.
  always_comb begin
    state_next      = state;
    offset_next     = offset;
    size_next       = size;
    zext_next       = zext;
    req_ready_next  = req_ready;
    resp_valid_next = resp_valid;
    resp_rdata_next = resp_rdata;
    resp_err_next   = resp_err;
    araddr_next     = maxi_araddr;
    arvalid_next    = maxi_arvalid;
    rready_next     = maxi_rready;
    awaddr_next     = maxi_awaddr;
    awvalid_next    = maxi_awvalid;
    wdata_next      = maxi_wdata;
    wstrb_next      = maxi_wstrb;
    wvalid_next     = maxi_wvalid;
    bready_next     = maxi_bready;

    case (state)
      IDLE: begin
        if (req_valid) begin
          offset_next    = req_addr[1:0];
          size_next      = req_size;
          zext_next      = req_unsigned;
          req_ready_next = 1'b0;
          if (misaligned) begin
            // Rejected locally: answer next cycle without touching the bus.
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
            resp_rdata_next = 32'h0;
            state_next      = RESP;
          end else if (req_wen) begin
            awaddr_next  = {req_addr[31:2], 2'b00};
            wdata_next   = req_wdata << {req_addr[1:0], 3'b000};
            wstrb_next   = make_strobe(req_size, req_addr[1:0]);
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            state_next   = WR_REQ;
          end else begin
            araddr_next  = {req_addr[31:2], 2'b00};
            arvalid_next = 1'b1;
            state_next   = RD_ADDR;
          end
        end
      end

      RD_ADDR: begin
        if (maxi_arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (maxi_rvalid) begin
          rready_next     = 1'b0;
          resp_valid_next = 1'b1;
          resp_rdata_next = extend_load(maxi_rdata, offset, size, zext);
          resp_err_next   = (maxi_rresp != 2'b00);
          state_next      = RESP;
        end
      end

      WR_REQ: begin
        // Address and data channels retire independently, in either order.
        if (maxi_awready) begin
          awvalid_next = 1'b0;
        end
        if (maxi_wready) begin
          wvalid_next = 1'b0;
        end
        if (aw_done && w_done) begin
          bready_next = 1'b1;
          state_next  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (maxi_bvalid) begin
          bready_next     = 1'b0;
          resp_valid_next = 1'b1;
          resp_rdata_next = 32'h0;
          resp_err_next   = (maxi_bresp != 2'b00);
          state_next      = RESP;
        end
      end

      RESP: begin
        if (resp_ready) begin
          resp_valid_next = 1'b0;
          req_ready_next  = 1'b1;
          state_next      = IDLE;
        end
      end

      default: begin
        state_next     = IDLE;
        req_ready_next = 1'b1;
      end
    endcase
  end

  // State, held request attributes and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      offset       <= 2'b00;
      size         <= 2'b00;
      zext         <= 1'b0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'h0;
      resp_err     <= 1'b0;
      maxi_araddr  <= 32'h0;
      maxi_arvalid <= 1'b0;
      maxi_rready  <= 1'b0;
      maxi_awaddr  <= 32'h0;
      maxi_awvalid <= 1'b0;
      maxi_wdata   <= 32'h0;
      maxi_wstrb   <= 4'h0;
      maxi_wvalid  <= 1'b0;
      maxi_bready  <= 1'b0;
    end else begin
      state        <= state_next;
      offset       <= offset_next;
      size         <= size_next;
      zext         <= zext_next;
      req_ready    <= req_ready_next;
      resp_valid   <= resp_valid_next;
      resp_rdata   <= resp_rdata_next;
      resp_err     <= resp_err_next;
      maxi_araddr  <= araddr_next;
      maxi_arvalid <= arvalid_next;
      maxi_rready  <= rready_next;
      maxi_awaddr  <= awaddr_next;
      maxi_awvalid <= awvalid_next;
      maxi_wdata   <= wdata_next;
      maxi_wstrb   <= wstrb_next;
      maxi_wvalid  <= wvalid_next;
      maxi_bready  <= bready_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_axi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_axi_master
//  Description : Self-checking bench for lsu_axi_master. A behavioural
//                AXI4-Lite responder with programmable per-channel delays
//                serves the bus; a byte-level memory model predicts results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] maxi_araddr;
  logic        maxi_arvalid;
  logic        maxi_arready;
  logic [31:0] maxi_rdata;
  logic [1:0]  maxi_rresp;
  logic        maxi_rvalid;
  logic        maxi_rready;
  logic [31:0] maxi_awaddr;
  logic        maxi_awvalid;
  logic        maxi_awready;
  logic [31:0] maxi_wdata;
  logic [3:0]  maxi_wstrb;
  logic        maxi_wvalid;
  logic        maxi_wready;
  logic [1:0]  maxi_bresp;
  logic        maxi_bvalid;
  logic        maxi_bready;

  int checks   = 0;
  int failures = 0;

  // Responder knobs (written by the stimulus block only).
  int         ar_delay  = 0;
  int         r_delay   = 0;
  int         aw_delay  = 0;
  int         w_delay   = 0;
  int         b_delay   = 0;
  logic [1:0] rresp_cfg = 2'b00;
  logic [1:0] bresp_cfg = 2'b00;

  // Responder state (written by the responder block only).
  logic [31:0] bus_mem [16];
  bit          rd_pending, aw_got, w_got, b_pending;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [3:0]  wr_strb;
  int          ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
  logic [31:0] cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  int          writes_seen;
  logic        p_arvalid, p_rready, p_awvalid, p_wvalid, p_bready;
  logic [31:0] p_araddr, p_awaddr, p_wdata;
  logic [3:0]  p_wstrb;

  // Reference model state (stimulus block only).
  logic [7:0]  model_mem [64];
  int          exp_writes = 0;
  int          o_lat, o_ar, o_aw, o_w, o_ovl, o_busy_rdy;
  logic [31:0] o_araddr, o_rdata;
  logic        o_err;

  lsu_axi_master dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .maxi_araddr  (maxi_araddr),
    .maxi_arvalid (maxi_arvalid),
    .maxi_arready (maxi_arready),
    .maxi_rdata   (maxi_rdata),
    .maxi_rresp   (maxi_rresp),
    .maxi_rvalid  (maxi_rvalid),
    .maxi_rready  (maxi_rready),
    .maxi_awaddr  (maxi_awaddr),
    .maxi_awvalid (maxi_awvalid),
    .maxi_awready (maxi_awready),
    .maxi_wdata   (maxi_wdata),
    .maxi_wstrb   (maxi_wstrb),
    .maxi_wvalid  (maxi_wvalid),
    .maxi_wready  (maxi_wready),
    .maxi_bresp   (maxi_bresp),
    .maxi_bvalid  (maxi_bvalid),
    .maxi_bready  (maxi_bready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'h9E3779B9 * 32'(i + 1)) ^ 32'h0F0F0F0F;
  endfunction

  function automatic logic [31:0] model_word(input int idx);
    return {model_mem[idx*4+3], model_mem[idx*4+2], model_mem[idx*4+1], model_mem[idx*4]};
  endfunction

  // Expected load value: pick nbytes starting at byte 'off', then extend.
  function automatic logic [31:0] model_load(input logic [31:0] word, input int off,
                                            input int nbytes, input bit uns);
    longint unsigned v;
    longint unsigned span;
    v    = longint'(word) >> (8 * off);
    span = 64'd1 << (8 * nbytes);
    v    = v % span;
    if (!uns && v >= span / 2) v = v + (64'h1_0000_0000 - span);
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic resp_clear();
    maxi_arready = 1'b0; maxi_rvalid = 1'b0; maxi_rdata = 32'h0; maxi_rresp = 2'b00;
    maxi_awready = 1'b0; maxi_wready = 1'b0; maxi_bvalid = 1'b0; maxi_bresp = 2'b00;
    rd_pending = 0; aw_got = 0; w_got = 0; b_pending = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
  endtask

  // Behavioural AXI4-Lite responder; reacts 1 time unit after each rising edge.
  initial begin : responder
    for (int i = 0; i < 16; i++) bus_mem[i] = init_word(i);
    resp_clear();
    writes_seen = 0;
    cap_awaddr = 32'h0; cap_wdata = 32'h0; cap_wstrb = 4'h0;
    rd_addr = 32'h0; wr_addr = 32'h0; wr_data = 32'h0; wr_strb = 4'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        resp_clear();
      end else begin
        if (p_arvalid && maxi_arready) begin rd_pending = 1; rd_addr = p_araddr; r_cnt = 0; end
        if (p_rready && maxi_rvalid)   begin maxi_rvalid = 1'b0; rd_pending = 0; end
        if (p_awvalid && maxi_awready) begin aw_got = 1; wr_addr = p_awaddr; end
        if (p_wvalid && maxi_wready)   begin w_got = 1; wr_data = p_wdata; wr_strb = p_wstrb; end
        if (p_bready && maxi_bvalid)   begin maxi_bvalid = 1'b0; b_pending = 0; end
        if (aw_got && w_got) begin
          if (bresp_cfg == 2'b00) begin
            for (int l = 0; l < 4; l++)
              if (wr_strb[l]) bus_mem[wr_addr[5:2]][8*l +: 8] = wr_data[8*l +: 8];
          end
          cap_awaddr = wr_addr; cap_wdata = wr_data; cap_wstrb = wr_strb;
          writes_seen++;
          aw_got = 0; w_got = 0; b_pending = 1; b_cnt = 0;
        end
        if (!maxi_arvalid) ar_cnt = 0;
        maxi_arready = maxi_arvalid && (ar_cnt >= ar_delay);
        if (maxi_arvalid) ar_cnt++;
        if (!maxi_awvalid) aw_cnt = 0;
        maxi_awready = maxi_awvalid && (aw_cnt >= aw_delay);
        if (maxi_awvalid) aw_cnt++;
        if (!maxi_wvalid) w_cnt = 0;
        maxi_wready = maxi_wvalid && (w_cnt >= w_delay);
        if (maxi_wvalid) w_cnt++;
        if (rd_pending && !maxi_rvalid) begin
          if (r_cnt >= r_delay) begin
            maxi_rvalid = 1'b1; maxi_rdata = bus_mem[rd_addr[5:2]]; maxi_rresp = rresp_cfg;
          end else r_cnt++;
        end
        if (b_pending && !maxi_bvalid) begin
          if (b_cnt >= b_delay) begin maxi_bvalid = 1'b1; maxi_bresp = bresp_cfg; end
          else b_cnt++;
        end
      end
      p_arvalid = maxi_arvalid; p_araddr = maxi_araddr; p_rready = maxi_rready;
      p_awvalid = maxi_awvalid; p_awaddr = maxi_awaddr; p_wvalid = maxi_wvalid;
      p_wdata = maxi_wdata; p_wstrb = maxi_wstrb; p_bready = maxi_bready;
    end
  end

  // One request end to end: predict, issue, monitor the bus, check, consume.
  task automatic txn(input bit wen, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [1:0] sz, input bit uns, input int hold, input string tag);
    int          off, idx, nbytes, lat, e_lat;
    bit          mis, berr, e_err;
    logic [31:0] e_rdata, e_strb, aligned;
    off     = int'(addr[1:0]);
    idx     = int'(addr[5:2]);
    nbytes  = 1 << sz;
    aligned = addr & 32'hFFFF_FFFC;
    mis     = (sz == 2'd3) || ((off % nbytes) != 0);
    berr    = wen ? (bresp_cfg != 2'b00) : (rresp_cfg != 2'b00);
    e_err   = mis || berr;
    e_rdata = 32'h0;
    e_strb  = 32'h0;
    if (mis) begin
      e_lat = 1;
    end else if (wen) begin
      e_lat  = 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay;
      e_strb = ((32'd1 << nbytes) - 32'd1) << off;
      exp_writes++;
      if (!berr)
        for (int i = 0; i < nbytes; i++) model_mem[idx*4+off+i] = 8'(wd >> (8*i));
    end else begin
      e_lat   = 3 + ar_delay + r_delay;
      e_rdata = model_load(model_word(idx), off, nbytes, uns);
    end

    chk({tag, "/req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd;
    req_size = sz; req_unsigned = uns;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom(); req_wdata = $urandom();

    lat = 1; o_ar = 0; o_aw = 0; o_w = 0; o_ovl = 0; o_busy_rdy = 0; o_araddr = 32'h0;
    while (!resp_valid && lat <= 60) begin
      if (maxi_arvalid) begin o_ar++; o_araddr = maxi_araddr; end
      if (maxi_awvalid) o_aw++;
      if (maxi_wvalid) o_w++;
      if (maxi_bready && (maxi_awvalid || maxi_wvalid)) o_ovl++;
      if (req_ready) o_busy_rdy++;
      @(negedge clk);
      lat++;
    end
    o_lat = lat; o_rdata = resp_rdata; o_err = resp_err;
    chk({tag, "/resp_valid"}, resp_valid, 1);
    if (resp_valid) begin
      chk({tag, "/latency"}, o_lat, e_lat);
      chk({tag, "/rdata"}, o_rdata, e_rdata);
      chk({tag, "/err"}, o_err, e_err);
      chk({tag, "/req_ready_busy"}, o_busy_rdy + int'(req_ready), 0);
      chk({tag, "/ar_cycles"}, o_ar, (!mis && !wen) ? ar_delay + 1 : 0);
      chk({tag, "/aw_cycles"}, o_aw, (!mis && wen) ? aw_delay + 1 : 0);
      chk({tag, "/w_cycles"}, o_w, (!mis && wen) ? w_delay + 1 : 0);
      chk({tag, "/bready_early"}, o_ovl, 0);
      chk({tag, "/write_count"}, writes_seen, exp_writes);
      if (!mis && !wen) chk({tag, "/araddr"}, o_araddr, aligned);
      if (!mis && wen) begin
        chk({tag, "/awaddr"}, cap_awaddr, aligned);
        chk({tag, "/wstrb"}, cap_wstrb, e_strb);
        if (!berr) chk({tag, "/mem_word"}, bus_mem[idx], model_word(idx));
      end
      for (int h = 0; h < hold; h++) begin
        chk({tag, "/stall_valid"}, resp_valid, 1);
        chk({tag, "/stall_rdata"}, resp_rdata, e_rdata);
        chk({tag, "/stall_err"}, resp_err, e_err);
        chk({tag, "/stall_req_ready"}, req_ready, 0);
        chk({tag, "/stall_bus_idle"},
            {maxi_arvalid, maxi_rready, maxi_awvalid, maxi_wvalid, maxi_bready}, 0);
        @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk({tag, "/resp_consumed"}, resp_valid, 0);
      chk({tag, "/req_ready_back"}, req_ready, 1);
    end
  endtask

  // Safety net in case a wait loop is ever defeated.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Directed steps followed by a randomized phase.
  initial begin : stimulus
    int          n;
    int          idx, off;
    logic [1:0]  sz;
    logic [31:0] addr;

    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 4; b++) model_mem[i*4+b] = 8'(init_word(i) >> (8*b));

    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset/req_ready", req_ready, 1);
    chk("reset/resp_valid", resp_valid, 0);
    chk("reset/resp_rdata", resp_rdata, 0);
    chk("reset/resp_err", resp_err, 0);
    chk("reset/bus_valids", {maxi_arvalid, maxi_rready, maxi_awvalid, maxi_wvalid, maxi_bready}, 0);

    // Word store then word load.
    txn(1, 32'h8000_0004, 32'hDEAD_BEEF, 2'd2, 0, 0, "sw");
    chk("sw/wstrb_lit", cap_wstrb, 4'b1111);
    txn(0, 32'h8000_0004, 32'h0, 2'd2, 0, 0, "lw");
    chk("lw/rdata_lit", o_rdata, 32'hDEAD_BEEF);
    chk("lw/araddr_lit", o_araddr, 32'h8000_0004);
    chk("lw/latency_lit", o_lat, 3);

    // Sub-word loads from 0x80FF7F01.
    txn(1, 32'h8000_0008, 32'h80FF_7F01, 2'd2, 0, 0, "sw2");
    txn(0, 32'h8000_000B, 32'h0, 2'd0, 0, 0, "lb");
    chk("lb/rdata_lit", o_rdata, 32'hFFFF_FF80);
    txn(0, 32'h8000_000B, 32'h0, 2'd0, 1, 0, "lbu");
    chk("lbu/rdata_lit", o_rdata, 32'h0000_0080);
    txn(0, 32'h8000_000A, 32'h0, 2'd1, 0, 0, "lh");
    chk("lh/rdata_lit", o_rdata, 32'hFFFF_80FF);
    txn(0, 32'h8000_0008, 32'h0, 2'd1, 1, 0, "lhu");
    chk("lhu/rdata_lit", o_rdata, 32'h0000_7F01);

    // Sub-word stores.
    txn(1, 32'h8000_0002, 32'h0000_00AB, 2'd0, 0, 0, "sb");
    chk("sb/awaddr_lit", cap_awaddr, 32'h8000_0000);
    chk("sb/wstrb_lit", cap_wstrb, 4'b0100);
    chk("sb/wdata_lit", cap_wdata, 32'h00AB_0000);
    txn(1, 32'h8000_0006, 32'h0000_1234, 2'd1, 0, 0, "sh");
    chk("sh/wstrb_lit", cap_wstrb, 4'b1100);

    // Write channel skew: AW accepted 3 cycles late, W immediately.
    aw_delay = 3;
    txn(1, 32'h8000_000C, 32'h1122_3344, 2'd2, 0, 0, "skew");
    chk("skew/w_cycles_lit", o_w, 1);
    chk("skew/aw_cycles_lit", o_aw, 4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("skew/single_resp", resp_valid, 0);
    end
    aw_delay = 0;

    // Misaligned word load never reaches the bus.
    txn(0, 32'h8000_0002, 32'h0, 2'd2, 0, 0, "misaligned");
    chk("misaligned/err_lit", o_err, 1);
    chk("misaligned/latency_lit", o_lat, 1);

    // Slave error on the read data channel.
    rresp_cfg = 2'b10;
    txn(0, 32'h8000_0004, 32'h0, 2'd2, 0, 0, "rresp_err");
    chk("rresp_err/err_lit", o_err, 1);
    rresp_cfg = 2'b00;

    // Response backpressure for 5 cycles.
    txn(0, 32'h8000_0008, 32'h0, 2'd2, 0, 5, "backpressure");

    // Reset while waiting for read data, then a clean load.
    r_delay = 5;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010; req_size = 2'd2; req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!maxi_rready && n < 20) begin @(negedge clk); n++; end
    chk("rst_mid/in_rd_data", maxi_rready, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid/bus_valids", {maxi_arvalid, maxi_rready, maxi_awvalid, maxi_wvalid, maxi_bready}, 0);
    chk("rst_mid/resp_valid", resp_valid, 0);
    chk("rst_mid/resp_rdata", resp_rdata, 0);
    chk("rst_mid/resp_err", resp_err, 0);
    rst = 1'b0;
    r_delay = 0;
    @(negedge clk);
    chk("rst_mid/req_ready", req_ready, 1);
    chk("rst_mid/resp_quiet", resp_valid, 0);
    txn(0, 32'h8000_0010, 32'h0, 2'd2, 0, 0, "after_rst");

    // Randomized accesses with random channel delays and occasional errors.
    for (int t = 0; t < 40; t++) begin
      ar_delay  = $urandom_range(0, 2);
      r_delay   = $urandom_range(0, 2);
      aw_delay  = $urandom_range(0, 3);
      w_delay   = $urandom_range(0, 3);
      b_delay   = $urandom_range(0, 2);
      rresp_cfg = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bresp_cfg = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      sz        = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      idx       = $urandom_range(0, 15);
      off       = $urandom_range(0, 3);
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) off = off & ~((1 << sz) - 1);
      addr      = 32'h8000_0000 + 32'(idx * 4 + off);
      txn(bit'($urandom_range(0, 1)), addr, $urandom(), sz, bit'($urandom_range(0, 1)),
          $urandom_range(0, 2), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_axi_master.md
# lsu_axi_master

AXI4-Lite initiator on the LSU side of the core, the other end of the data-memory SRAM/AXI responder. Takes one load or store request at a time from the execute stage and drives the AR/R and AW/W/B channels. Converts byte/half/word accesses into word-aligned bus beats, generating byte strobes for stores and extracting plus sign/zero-extending load data. Returns a single response per request with data or error.

## Interface
- No parameters. Data and address widths are fixed at 32 bits.
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle; high only in IDLE
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- req_unsigned  in  1  load zero-extends when 1
- resp_valid  out  1  response held until resp_ready
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misaligned, illegal size, or bus error
- maxi_araddr  out  32; maxi_arvalid  out  1; maxi_arready  in  1
- maxi_rdata  in  32; maxi_rresp  in  2; maxi_rvalid  in  1; maxi_rready  out  1
- maxi_awaddr  out  32; maxi_awvalid  out  1; maxi_awready  in  1
- maxi_wdata  out  32; maxi_wstrb  out  4; maxi_wvalid  out  1; maxi_wready  in  1
- maxi_bresp  in  2; maxi_bvalid  in  1; maxi_bready  out  1

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE: on req_valid, latch addr[1:0], size, unsigned, wen, data. Then:
  - misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 3 -> RESP with resp_err=1 and no bus activity;
  - load -> RD_ADDR;
  - store -> WR_REQ.
- Bus address is always {req_addr[31:2],2'b00}.
- RD_ADDR: arvalid=1 until arready, then -> RD_DATA. arvalid never drops before the handshake.
- RD_DATA: rready=1. On rvalid:
  - shifted = rdata >> (8*offset);
  - byte: bits [7:0] extended; half: bits [15:0] extended; word: as-is;
  - resp_err = (rresp != 0);
  - -> RESP.
- WR_REQ:
  - awvalid and wvalid rise together on entry.
  - Each drops independently after its own handshake. Any order is legal, and both may complete in the same cycle.
  - wstrb = (byte 4'b0001, half 4'b0011, word 4'b1111) << offset.
  - wdata = req_wdata << (8*offset).
  - -> WR_RESP once both handshakes are done.
- WR_RESP: bready=1. On bvalid, resp_err = (bresp != 0), resp_rdata = 0, -> RESP.
- RESP: resp_valid=1 with data/err stable until resp_ready, then -> IDLE.
- Reset values: req_ready=1 after the reset cycle, all other outputs 0, state IDLE.
- Reset mid-operation: all valids/readies drop at the next edge and the transaction is abandoned. The responder is reset by the same rst.

## Timing
- All outputs are registered, with no combinational path from bus inputs to bus outputs.
- Request accepted at edge N, so arvalid/awvalid/wvalid are high in cycle N+1.
- Zero-wait responder: AR handshake at N+1, R at N+2, resp_valid at N+3. Minimum load latency is 3 cycles.
- Store minimum is also 3 cycles: AW/W at N+1, B at N+2, resp_valid at N+3.
- Misaligned/illegal: resp_valid at N+1.
- Outstanding transactions: at most one. No new request is accepted until the response is consumed (req_ready=0 outside IDLE).
- resp_ready held low stalls in RESP indefinitely, and the bus stays idle meanwhile.

## Test plan
- Word load: addr 0x80000004, memory word 0xDEADBEEF, zero-wait responder -> araddr 0x80000004; resp_rdata 0xDEADBEEF, err 0 at N+3.
- Byte and half loads from word 0x80FF7F01:
  - lb at offset 3 -> 0xFFFFFF80;
  - lbu at offset 3 -> 0x00000080;
  - lh at offset 2 -> 0xFFFF80FF;
  - lhu at offset 0 -> 0x00007F01.
- Stores:
  - sb 0xAB at 0x80000002 -> awaddr 0x80000000, wstrb 4'b0100, wdata 0x00AB0000;
  - sh at offset 2 -> wstrb 4'b1100.
- Channel skew: awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, bready only afterwards, single response.
- Errors:
  - lw at 0x80000002 -> resp_err=1 at N+1, arvalid never asserted;
  - rresp=2'b10 -> resp_err=1.
- Backpressure and reset: resp_ready low 5 cycles -> resp_valid/rdata stable, req_ready=0. rst asserted while in RD_DATA -> all outputs 0 the next cycle, then a fresh load completes correctly.
